// File: rtl/load_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : load_unit_if
//  Purpose  : Issue, data-memory and writeback signals of the load unit.
//             'master' is the load unit side; it drives the memory request
//             and the writeback. 'slave' is the surrounding pipeline and
//             memory side.
//  Revision : 1.0  initial release
// ============================================================================
interface load_unit_if #(
    parameter int XLEN = 32
);
    // Issue from decode/execute
    logic            start;
    logic [6:0]      op_code;
    logic [2:0]      funct3;
    logic [XLEN-1:0] base_addr;
    logic [11:0]     offset;
    logic [4:0]      rd_addr;
    logic            busy;

    // Data memory port
    logic            mem_req;
    logic [XLEN-1:0] mem_addr;
    logic            mem_gnt;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;

    // Register writeback and error reporting
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            load_err;

    modport master (
        input  start, op_code, funct3, base_addr, offset, rd_addr,
        output busy,
        output mem_req, mem_addr,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output wb_valid, wb_rd, wb_data, load_err
    );

    modport slave (
        output start, op_code, funct3, base_addr, offset, rd_addr,
        input  busy,
        input  mem_req, mem_addr,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  wb_valid, wb_rd, wb_data, load_err
    );
endinterface
`default_nettype wire

// File: rtl/load_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_unit
//  Purpose  : Executes LB/LH/LW/LBU/LHU (plus LD/LWU when XLEN=64) against a
//             word-wide data memory with a req/gnt + rvalid handshake.
//             Forms the effective address, checks alignment, extracts and
//             sign/zero-extends the addressed lane and issues a one-cycle
//             register writeback. Misaligned or illegal loads pulse load_err.
//  Revision : 1.0  initial release
// ============================================================================
module load_unit #(
    parameter int         XLEN    = 32,
    parameter logic [6:0] LOAD_OP = 7'b0000011
) (
    input wire          clk,
    input wire          rst,
    load_unit_if.master bus
);

    // Byte-offset width inside one memory word and the mask clearing it
    localparam int              c_off_w     = $clog2(XLEN / 8);
    localparam logic [XLEN-1:0] c_lane_mask = XLEN'(XLEN / 8 - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t               state_q,    state_d;
    logic [c_off_w-1:0]   lane_q,     lane_d;
    logic [2:0]           funct3_q,   funct3_d;
    logic [4:0]           rd_q,       rd_d;
    logic                 busy_q,     busy_d;
    logic                 mem_req_q,  mem_req_d;
    logic [XLEN-1:0]      mem_addr_q, mem_addr_d;
    logic                 wb_valid_q, wb_valid_d;
    logic [4:0]           wb_rd_q,    wb_rd_d;
    logic [XLEN-1:0]      wb_data_q,  wb_data_d;
    logic                 load_err_q, load_err_d;

    logic [XLEN-1:0]      w_ea;
    logic                 w_accept;
    logic                 w_legal;
    logic                 w_misaligned;
    logic [XLEN-1:0]      w_shifted;
    logic [XLEN-1:0]      w_load;

    // Effective address wraps modulo 2^XLEN; a load is taken only from IDLE
    assign w_ea     = bus.base_addr + XLEN'($signed(bus.offset));
    assign w_accept = bus.start && (state_q == S_IDLE) && (bus.op_code == LOAD_OP);

    // Decode funct3 into legality and natural-alignment violation
    always_comb begin
        w_legal      = 1'b0;
        w_misaligned = 1'b0;
        case (bus.funct3)
            3'b000, 3'b100: begin
                w_legal = 1'b1;
            end
            3'b001, 3'b101: begin
                w_legal      = 1'b1;
                w_misaligned = w_ea[0];
            end
            3'b010: begin
                w_legal      = 1'b1;
                w_misaligned = |w_ea[1:0];
            end
            3'b011: begin
                w_legal      = (XLEN == 64);
                w_misaligned = |w_ea[2:0];
            end
            3'b110: begin
                w_legal      = (XLEN == 64);
                w_misaligned = |w_ea[1:0];
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
    end

    // Bring the addressed lane down to bit 0 and extend it; alignment was
    // already enforced, so the lane never straddles the word boundary
    assign w_shifted = bus.mem_rdata >> {lane_q, 3'b000};

    always_comb begin
        case (funct3_q)
            3'b000:  w_load = XLEN'($signed(w_shifted[7:0]));
            3'b001:  w_load = XLEN'($signed(w_shifted[15:0]));
            3'b010:  w_load = XLEN'($signed(w_shifted[31:0]));
            3'b100:  w_load = XLEN'(w_shifted[7:0]);
            3'b101:  w_load = XLEN'(w_shifted[15:0]);
            3'b110:  w_load = XLEN'(w_shifted[31:0]);
            default: w_load = w_shifted;
        endcase
    end

    // Next-state and next-output logic; every output is a flop driven from
    // the state being entered so it lines up with that state's cycle
    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        funct3_d   = funct3_q;
        rd_d       = rd_q;
        mem_addr_d = mem_addr_q;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    lane_d   = w_ea[c_off_w-1:0];
                    funct3_d = bus.funct3;
                    rd_d     = bus.rd_addr;
                    if (w_legal && !w_misaligned) begin
                        state_d    = S_REQ;
                        mem_addr_d = w_ea & ~c_lane_mask;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_REQ: begin
                if (bus.mem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.mem_rvalid) begin
                    state_d   = S_DONE;
                    wb_rd_d   = rd_q;
                    wb_data_d = w_load;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d     = (state_d != S_IDLE);
        mem_req_d  = (state_d == S_REQ);
        wb_valid_d = (state_d == S_DONE);
        load_err_d = (state_d == S_ERR);
    end

    // State and output registers; reset abandons any access in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            lane_q     <= '0;
            funct3_q   <= '0;
            rd_q       <= '0;
            busy_q     <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            funct3_q   <= funct3_d;
            rd_q       <= rd_d;
            busy_q     <= busy_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.mem_req  = mem_req_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.wb_valid = wb_valid_q;
    assign bus.wb_rd    = wb_rd_q;
    assign bus.wb_data  = wb_data_q;
    assign bus.load_err = load_err_q;

endmodule
`default_nettype wire

// File: tb/tb_load_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_load_unit
//  Purpose  : Drives an XLEN=32 and an XLEN=64 load unit with identical
//             stimulus and checks each against its own expectations:
//             directed table, reset-in-WAIT sequence, random transactions.
//  Revision : 1.0  initial release
// ============================================================================
module tb_load_unit;

    localparam logic [6:0] LOAD_OP = 7'b0000011;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [63:0] base;
        logic [11:0] off;
        logic [4:0]  rd;
        logic [63:0] rdata;
        int          gd;     // extra cycles before mem_gnt
        int          rdl;    // extra cycles between gnt and rvalid
        bit          poke;   // start again while busy
        bit          stray;  // stray rvalid in REQ and stray gnt in WAIT
    } stim_t;

    typedef struct {
        bit          acc;
        bit          err;
        logic [63:0] addr;
        logic [63:0] data;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e32;
        exp_t  e64;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [6:0]  op = '0;
    logic [2:0]  f3 = '0;
    logic [63:0] base = '0;
    logic [11:0] off = '0;
    logic [4:0]  rd = '0;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [63:0] rdata = '0;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [4:0]  last_rd   [2];
    logic [63:0] last_data [2];

    always #5 clk = ~clk;

    load_unit_if #(.XLEN(32)) if32 ();
    load_unit_if #(.XLEN(64)) if64 ();

    assign if32.start      = start;
    assign if32.op_code    = op;
    assign if32.funct3     = f3;
    assign if32.base_addr  = base[31:0];
    assign if32.offset     = off;
    assign if32.rd_addr    = rd;
    assign if32.mem_gnt    = gnt;
    assign if32.mem_rvalid = rvalid;
    assign if32.mem_rdata  = rdata[31:0];

    assign if64.start      = start;
    assign if64.op_code    = op;
    assign if64.funct3     = f3;
    assign if64.base_addr  = base;
    assign if64.offset     = off;
    assign if64.rd_addr    = rd;
    assign if64.mem_gnt    = gnt;
    assign if64.mem_rvalid = rvalid;
    assign if64.mem_rdata  = rdata;

    load_unit #(.XLEN(32), .LOAD_OP(LOAD_OP)) u_dut32 (.clk(clk), .rst(rst), .bus(if32));
    load_unit #(.XLEN(64), .LOAD_OP(LOAD_OP)) u_dut64 (.clk(clk), .rst(rst), .bus(if64));

    // Reference: result of one load computed straight from the ISA rules
    function automatic exp_t model(input int xlen, input stim_t s);
        exp_t        e;
        logic [63:0] ea;
        logic [63:0] v;
        logic [63:0] m;
        int          size;
        int          nb;
        bit          sgn;
        bit          legal;
        nb    = xlen / 8;
        ea    = s.base + {{52{s.off[11]}}, s.off};
        if (xlen == 32) ea[63:32] = '0;
        legal = 1'b1;
        sgn   = 1'b1;
        size  = 1;
        case (s.f3)
            3'd0: size = 1;
            3'd1: size = 2;
            3'd2: size = 4;
            3'd3: begin size = 8; legal = (xlen == 64); end
            3'd4: begin size = 1; sgn = 1'b0; end
            3'd5: begin size = 2; sgn = 1'b0; end
            3'd6: begin size = 4; sgn = 1'b0; legal = (xlen == 64); end
            default: legal = 1'b0;
        endcase
        e.acc  = (s.op == LOAD_OP);
        e.err  = !legal || ((ea & 64'(size - 1)) != 64'd0);
        e.addr = ea & ~64'(nb - 1);
        v = s.rdata >> (8 * (ea & 64'(nb - 1)));
        if (size < 8) begin
            m = (64'd1 << (8 * size)) - 64'd1;
            v = v & m;
            if (sgn && v[8 * size - 1]) v = v | ~m;
        end
        if (xlen == 32) v = v & 64'hFFFF_FFFF;
        e.data = v;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic sample(input int d, output logic [3:0] flags, output logic [63:0] addr,
                          output logic [63:0] data, output logic [4:0] wrd);
        if (d == 0) begin
            flags = {if32.busy, if32.mem_req, if32.wb_valid, if32.load_err};
            addr  = {32'h0, if32.mem_addr};
            data  = {32'h0, if32.wb_data};
            wrd   = if32.wb_rd;
        end else begin
            flags = {if64.busy, if64.mem_req, if64.wb_valid, if64.load_err};
            addr  = if64.mem_addr;
            data  = if64.wb_data;
            wrd   = if64.wb_rd;
        end
    endtask

    task automatic check_zero(input string tag);
        logic [3:0]  fl;
        logic [63:0] a;
        logic [63:0] dt;
        logic [4:0]  r;
        for (int d = 0; d < 2; d++) begin
            sample(d, fl, a, dt, r);
            check($sformatf("%s x%0d flags", tag, d ? 64 : 32), {60'h0, fl}, 64'h0);
            check($sformatf("%s x%0d mem_addr", tag, d ? 64 : 32), a, 64'h0);
            check($sformatf("%s x%0d wb_data", tag, d ? 64 : 32), dt, 64'h0);
            check($sformatf("%s x%0d wb_rd", tag, d ? 64 : 32), {59'h0, r}, 64'h0);
        end
    endtask

    // One transaction: start in cycle 0, gnt/rvalid per schedule; every cycle
    // both DUTs' flags, writeback hold values and request address are checked
    task automatic run_txn(input stim_t s, input exp_t e0, input exp_t e1, input string tag);
        exp_t        e [2];
        int          ld [2];
        int          gcyc;
        int          rcyc;
        int          lst;
        logic [3:0]  fl;
        logic [3:0]  efl;
        logic [63:0] a;
        logic [63:0] dt;
        logic [4:0]  r;
        e[0] = e0;
        e[1] = e1;
        gcyc = 1 + s.gd;
        rcyc = gcyc + 1 + s.rdl;
        lst  = 3;
        for (int d = 0; d < 2; d++) begin
            ld[d] = !e[d].acc ? 0 : (e[d].err ? 1 : rcyc + 1);
            if (ld[d] > lst) lst = ld[d];
        end
        for (int c = 0; c <= lst; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                sample(d, fl, a, dt, r);
                efl[3] = e[d].acc && c >= 1 && c <= ld[d];
                efl[2] = e[d].acc && !e[d].err && c >= 1 && c <= gcyc;
                efl[1] = e[d].acc && !e[d].err && c == ld[d];
                efl[0] = e[d].acc && e[d].err && c == 1;
                if (efl[1]) begin
                    last_rd[d]   = s.rd;
                    last_data[d] = e[d].data;
                end
                check($sformatf("%s x%0d c%0d busy/req/wb/err", tag, d ? 64 : 32, c),
                      {60'h0, fl}, {60'h0, efl});
                check($sformatf("%s x%0d c%0d wb_rd", tag, d ? 64 : 32, c),
                      {59'h0, r}, {59'h0, last_rd[d]});
                check($sformatf("%s x%0d c%0d wb_data", tag, d ? 64 : 32, c), dt, last_data[d]);
                if (efl[2])
                    check($sformatf("%s x%0d c%0d mem_addr", tag, d ? 64 : 32, c), a, e[d].addr);
            end
            if (c == 0) begin
                start = 1'b1; op = s.op; f3 = s.f3; base = s.base; off = s.off; rd = s.rd;
            end else if (c == 1 && s.poke && e0.acc) begin
                start = 1'b1; op = LOAD_OP; f3 = 3'b000; base = ~s.base; off = 12'h0; rd = ~s.rd;
            end else begin
                start = 1'b0; op = 7'($urandom); f3 = 3'($urandom);
                base = {$urandom, $urandom}; off = 12'($urandom); rd = 5'($urandom);
            end
            gnt    = (c == gcyc) || (s.stray && c == rcyc);
            rvalid = (c == rcyc) || (s.stray && c == 1 && s.gd > 0);
            rdata  = (c == rcyc) ? s.rdata : {$urandom, $urandom};
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t  tbl [14];
        stim_t s;

        tbl[0]  = '{'{LOAD_OP, 3'b000, 64'h1000, 12'h003, 5'd1, 64'h0000_0000_80FF_1234, 0, 0, 1'b0, 1'b0},
                    '{1'b1, 1'b0, 64'h1000, 64'h0000_0000_FFFF_FF80},
                    '{1'b1, 1'b0, 64'h1000, 64'hFFFF_FFFF_FFFF_FF80}};
        tbl[1]  = '{'{LOAD_OP, 3'b100, 64'h1000, 12'h003, 5'd2, 64'h0000_0000_80FF_1234, 0, 0, 1'b0, 1'b0},
                    '{1'b1, 1'b0, 64'h1000, 64'h0000_0000_0000_0080},
                    '{1'b1, 1'b0, 64'h1000, 64'h0000_0000_0000_0080}};
        tbl[2]  = '{'{LOAD_OP, 3'b101, 64'h1000, 12'h002, 5'd3, 64'h0000_0000_80FF_1234, 0, 0, 1'b0, 1'b0},
                    '{1'b1, 1'b0, 64'h1000, 64'h0000_0000_0000_80FF},
                    '{1'b1, 1'b0, 64'h1000, 64'h0000_0000_0000_80FF}};
        tbl[3]  = '{'{LOAD_OP, 3'b001, 64'h1000, 12'h002, 5'd4, 64'h0000_0000_80FF_1234, 0, 0, 1'b0, 1'b0},
                    '{1'b1, 1'b0, 64'h1000, 64'h0000_0000_FFFF_80FF},
                    '{1'b1, 1'b0, 64'h1000, 64'hFFFF_FFFF_FFFF_80FF}};
        tbl[4]  = '{'{LOAD_OP, 3'b001, 64'h1000, 12'hFFF, 5'd5, 64'h0000_0000_80FF_1234, 0, 0, 1'b0, 1'b0},
                    '{1'b1, 1'b1, 64'h0, 64'h0},
                    '{1'b1, 1'b1, 64'h0, 64'h0}};
        tbl[5]  = '{'{LOAD_OP, 3'b010, 64'h1000, 12'h000, 5'd6, 64'h0000_0000_80FF_1234, 3, 1, 1'b1, 1'b0},
                    '{1'b1, 1'b0, 64'h1000, 64'h0000_0000_80FF_1234},
                    '{1'b1, 1'b0, 64'h1000, 64'hFFFF_FFFF_80FF_1234}};
        tbl[6]  = '{'{LOAD_OP, 3'b011, 64'h0010, 12'h000, 5'd7, 64'h8000_0000_0000_0001, 0, 0, 1'b0, 1'b0},
                    '{1'b1, 1'b1, 64'h0, 64'h0},
                    '{1'b1, 1'b0, 64'h0010, 64'h8000_0000_0000_0001}};
        tbl[7]  = '{'{LOAD_OP, 3'b110, 64'h0010, 12'h004, 5'd8, 64'h8000_0000_0000_0001, 1, 0, 1'b0, 1'b0},
                    '{1'b1, 1'b1, 64'h0, 64'h0},
                    '{1'b1, 1'b0, 64'h0010, 64'h0000_0000_8000_0000}};
        tbl[8]  = '{'{LOAD_OP, 3'b111, 64'h0010, 12'h000, 5'd9, 64'h1234_5678_9ABC_DEF0, 0, 0, 1'b0, 1'b0},
                    '{1'b1, 1'b1, 64'h0, 64'h0},
                    '{1'b1, 1'b1, 64'h0, 64'h0}};
        tbl[9]  = '{'{LOAD_OP, 3'b010, 64'h2000, 12'h7FC, 5'd0, 64'h1122_3344_5566_7788, 1, 2, 1'b0, 1'b1},
                    '{1'b1, 1'b0, 64'h27FC, 64'h0000_0000_5566_7788},
                    '{1'b1, 1'b0, 64'h27F8, 64'h0000_0000_1122_3344}};
        tbl[10] = '{'{LOAD_OP, 3'b001, 64'hFFFF_FFFE, 12'h004, 5'd10, 64'h0000_0000_ABCD_0000, 0, 1, 1'b0, 1'b0},
                    '{1'b1, 1'b0, 64'h0, 64'h0000_0000_FFFF_ABCD},
                    '{1'b1, 1'b0, 64'h1_0000_0000, 64'hFFFF_FFFF_FFFF_ABCD}};
        tbl[11] = '{'{7'b0100011, 3'b010, 64'h1000, 12'h000, 5'd11, 64'h1, 0, 0, 1'b0, 1'b0},
                    '{1'b0, 1'b0, 64'h0, 64'h0},
                    '{1'b0, 1'b0, 64'h0, 64'h0}};
        tbl[12] = '{'{LOAD_OP, 3'b011, 64'h0014, 12'h000, 5'd12, 64'h1, 0, 0, 1'b0, 1'b0},
                    '{1'b1, 1'b1, 64'h0, 64'h0},
                    '{1'b1, 1'b1, 64'h0, 64'h0}};
        tbl[13] = '{'{LOAD_OP, 3'b010, 64'h1002, 12'h000, 5'd13, 64'h1, 0, 0, 1'b0, 1'b0},
                    '{1'b1, 1'b1, 64'h0, 64'h0},
                    '{1'b1, 1'b1, 64'h0, 64'h0}};

        for (int d = 0; d < 2; d++) begin
            last_rd[d]   = '0;
            last_data[d] = '0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // Directed vectors, applied back to back
        for (int i = 0; i < 14; i++)
            run_txn(tbl[i].s, tbl[i].e32, tbl[i].e64, $sformatf("vec%0d", i));

        // Reset while waiting for rvalid, then a late rvalid
        @(negedge clk);
        start = 1'b1; op = LOAD_OP; f3 = 3'b010; base = 64'h3000; off = 12'h0; rd = 5'd7;
        gnt = 1'b0; rvalid = 1'b0;
        @(negedge clk);
        check("rstwait x32 req", {60'h0, if32.busy, if32.mem_req, if32.wb_valid, if32.load_err}, 64'hC);
        check("rstwait x64 req", {60'h0, if64.busy, if64.mem_req, if64.wb_valid, if64.load_err}, 64'hC);
        start = 1'b0; gnt = 1'b1;
        @(negedge clk);
        check("rstwait x32 wait", {60'h0, if32.busy, if32.mem_req, if32.wb_valid, if32.load_err}, 64'h8);
        check("rstwait x64 wait", {60'h0, if64.busy, if64.mem_req, if64.wb_valid, if64.load_err}, 64'h8);
        gnt = 1'b0;
        rst = 1'b1;
        #1;
        check_zero("rst_async");
        @(negedge clk);
        rst = 1'b0; rvalid = 1'b1; rdata = 64'hDEAD_BEEF_CAFE_F00D;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            rvalid = 1'b0;
            check_zero($sformatf("post_rst%0d", k));
        end
        for (int d = 0; d < 2; d++) begin
            last_rd[d]   = '0;
            last_data[d] = '0;
        end

        // Random transactions against the reference model
        for (int i = 0; i < 200; i++) begin
            s.op    = ($urandom_range(0, 7) == 0) ? 7'b0110011 : LOAD_OP;
            s.f3    = 3'($urandom_range(0, 7));
            s.base  = {$urandom, $urandom};
            s.off   = 12'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                s.base[2:0] = 3'b000;
                s.off[2:0]  = 3'b000;
            end
            s.rd    = 5'($urandom);
            s.rdata = {$urandom, $urandom};
            s.gd    = $urandom_range(0, 3);
            s.rdl   = $urandom_range(0, 3);
            s.poke  = 1'($urandom);
            s.stray = 1'($urandom);
            run_txn(s, model(32, s), model(64, s), $sformatf("rnd%0d", i));
        end

        @(negedge clk);
        start = 1'b0; gnt = 1'b0; rvalid = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
